store_rmw_narrow: RTL and testbench

//  Store-side counterpart of immediate/load sign extension: narrows a 32-bit register value to

---
 rtl/store_rmw_narrow.sv | 154 +++++++++++++++
 tb/tb_store_rmw_narrow.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_narrow.sv
`default_nettype none
// ============================================================================
// Module   : store_rmw_narrow
// Purpose  : Narrows a 32-bit register value to a byte, halfword or word and
//            stores it into a word-only data memory. Byte and halfword stores
//            read the target word, merge the new lane in, and write it back.
//            busy stalls the CPU until a done or err pulse.
// Ports    : clk, rst_n (async, active low)
//            start/size/addr/wdata -> CPU store request, sampled in IDLE only
//            busy/done/err         -> status back to the CPU
//            mem_addr/mem_re/mem_rdata/mem_rvalid -> memory read channel
//            mem_we/mem_wdata/mem_wready          -> memory write channel
// Revision : 1.0  initial release
// ============================================================================
module store_rmw_narrow #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic        mem_wready
);

   localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);
   // Counter value at which the current waiting cycle is the last one allowed.
   localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(WAIT_MAX - 1);
   localparam logic [1:0] C_SIZE_B = 2'b00;
   localparam logic [1:0] C_SIZE_H = 2'b01;
   localparam logic [1:0] C_SIZE_W = 2'b10;
   localparam logic [1:0] C_SIZE_X = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

   logic              w_bad_req;
   logic [31:0]       w_merged;

   // Requests that can never be committed are rejected before any memory access.
   assign w_bad_req = (size == C_SIZE_X)
                   || ((size == C_SIZE_H) && addr[0])
                   || ((size == C_SIZE_W) && (addr[1:0] != 2'b00));

   // Lane insertion into the word just read; narrowing is plain truncation.
   always_comb begin
      w_merged = mem_rdata;
      case (size_q)
         C_SIZE_B: w_merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
         C_SIZE_H: w_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default:  w_merged = wdata_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      mem_wdata_d = mem_wdata_q;
      wait_cnt_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = addr;
               size_d  = size;
               wdata_d = wdata;
               if (w_bad_req) begin
                  state_d = S_ERR;
               end else if (size == C_SIZE_W) begin
                  mem_wdata_d = wdata;
                  state_d     = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            if (mem_rvalid) begin
               mem_wdata_d = w_merged;
               state_d     = S_WRITE;
            end else if (wait_cnt_q == C_WAIT_LAST) begin
               state_d = S_ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         S_WRITE: begin
            if (mem_wready) begin
               state_d = S_DONE;
            end else if (wait_cnt_q == C_WAIT_LAST) begin
               state_d = S_ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         wdata_q     <= '0;
         mem_wdata_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         wdata_q     <= wdata_d;
         mem_wdata_q <= mem_wdata_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   // Status and requests decode straight from the state register so an
   // asynchronous reset drops them at once.
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign mem_re    = (state_q == S_READ);
   assign mem_we    = (state_q == S_WRITE);
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_store_rmw_narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_rmw_narrow
// Purpose  : Self-checking bench for store_rmw_narrow. A word-array memory
//            model answers the DUT handshakes; expected words come from
//            mask-and-shift arithmetic on the store size and address.
// Revision : 1.0  initial release
// ============================================================================
module tb_store_rmw_narrow;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata = '0;
   logic        rvalid = 1'b0;
   logic        wready = 1'b0;
   logic        busy, done, err, mem_re, mem_we;
   logic [31:0] mem_addr, mem_wdata;

   logic        start4 = 1'b0;
   logic [31:0] rdata4 = '0;
   logic        rvalid4 = 1'b0;
   logic        wready4 = 1'b0;
   logic        busy4, done4, err4, mem_re4, mem_we4;
   logic [31:0] mem_addr4, mem_wdata4;

   logic [31:0] mem [64];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   store_rmw_narrow dut (
      .clk(clk), .rst_n(rst_n), .start(start), .size(size), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_re(mem_re),
      .mem_rdata(rdata), .mem_rvalid(rvalid), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_wready(wready)
   );

   store_rmw_narrow #(.WAIT_MAX(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .size(size), .addr(addr), .wdata(wdata),
      .busy(busy4), .done(done4), .err(err4), .mem_addr(mem_addr4), .mem_re(mem_re4),
      .mem_rdata(rdata4), .mem_rvalid(rvalid4), .mem_we(mem_we4), .mem_wdata(mem_wdata4),
      .mem_wready(wready4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Word that memory should hold after the store: the addressed lane replaced.
   function automatic logic [31:0] exp_merge(input logic [1:0] sz, input logic [31:0] a,
                                             input logic [31:0] wd, input logic [31:0] old);
      int unsigned sh;
      logic [31:0] mask;
      case (sz)
         2'b00:   begin sh = 8 * (a % 4);        mask = 32'h0000_00FF << sh; end
         2'b01:   begin sh = 16 * ((a / 2) % 2); mask = 32'h0000_FFFF << sh; end
         default: begin sh = 0;                  mask = 32'hFFFF_FFFF;       end
      endcase
      return (old & ~mask) | ((wd << sh) & mask);
   endfunction

   // One store on the main DUT; memory answers after rdly / wdly wait cycles.
   task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                            input int rdly, input int wdly, input bit spam);
      bit          legal, word, finished, both, addr_moved, data_moved;
      int          idx, re_n, we_n, done_n, err_n, done_cyc, err_cyc, exp_done;
      logic [31:0] old_w, exp_w, first_addr, first_wdata;
      legal = (sz != 2'b11) && ((a % (32'd1 << sz)) == 0);
      word  = (sz == 2'b10);
      idx   = int'(a[7:2]);
      old_w = mem[idx];
      exp_w = exp_merge(sz, a, wd, old_w);
      re_n = 0; we_n = 0; done_n = 0; err_n = 0; done_cyc = -1; err_cyc = -1;
      finished = 0; both = 0; addr_moved = 0; data_moved = 0;
      first_addr = '0; first_wdata = '0;
      @(negedge clk);
      start = 1'b1; size = sz; addr = a; wdata = wd;
      for (int cyc = 1; cyc <= 600 && !finished; cyc++) begin
         @(negedge clk);
         if (spam && busy) begin
            start = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = $urandom;
            wdata = $urandom;
         end else begin
            start = 1'b0;
         end
         rvalid = 1'b0;
         wready = 1'b0;
         rdata  = $urandom;
         if (mem_re && mem_we) both = 1;
         if (mem_re) begin
            re_n++;
            if (re_n == 1) first_addr = mem_addr;
            else if (mem_addr !== first_addr) addr_moved = 1;
            if (re_n == rdly + 1) begin
               rvalid = 1'b1;
               rdata  = mem[int'(mem_addr[7:2])];
            end
         end
         if (mem_we) begin
            we_n++;
            if (we_n == 1) begin
               first_wdata = mem_wdata;
               if (re_n == 0) first_addr = mem_addr;
               else if (mem_addr !== first_addr) addr_moved = 1;
            end else begin
               if (mem_wdata !== first_wdata) data_moved = 1;
               if (mem_addr !== first_addr) addr_moved = 1;
            end
            if (we_n == wdly + 1) begin
               wready = 1'b1;
               mem[int'(mem_addr[7:2])] = mem_wdata;
            end
         end
         if (done) begin done_n++; done_cyc = cyc; end
         if (err)  begin err_n++;  err_cyc = cyc;  end
         if (!busy) finished = 1;
      end
      check("finished", 32'(finished), 32'd1);
      check("re_we_excl", 32'(both), 32'd0);
      if (legal) begin
         exp_done = word ? 2 + wdly : 3 + rdly + wdly;
         check("done_count", done_n, 1);
         check("done_cycle", done_cyc, exp_done);
         check("err_count", err_n, 0);
         check("re_cycles", re_n, word ? 0 : rdly + 1);
         check("we_cycles", we_n, wdly + 1);
         check("mem_addr", first_addr, {a[31:2], 2'b00});
         check("mem_wdata", first_wdata, exp_w);
         check("addr_stable", 32'(addr_moved), 32'd0);
         check("wdata_stable", 32'(data_moved), 32'd0);
         check("mem_word", mem[idx], exp_w);
      end else begin
         check("err_count", err_n, 1);
         check("err_cycle", err_cyc, 1);
         check("done_count", done_n, 0);
         check("re_cycles", re_n, 0);
         check("we_cycles", we_n, 0);
         check("mem_word", mem[idx], old_w);
      end
      @(negedge clk);
      check("idle_after", 32'(busy), 32'd0);
   endtask

   // Store on the WAIT_MAX=4 instance whose memory never answers.
   task automatic run_timeout(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int          re_n, we_n, done_n, err_n, err_cyc;
      bit          finished;
      logic [31:0] addr_at_err, wdata_at_err;
      re_n = 0; we_n = 0; done_n = 0; err_n = 0; err_cyc = -1; finished = 0;
      addr_at_err = '0; wdata_at_err = '0;
      @(negedge clk);
      start4 = 1'b1; size = sz; addr = a; wdata = wd;
      for (int cyc = 1; cyc <= 50 && !finished; cyc++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (mem_re4) re_n++;
         if (mem_we4) we_n++;
         if (done4) done_n++;
         if (err4) begin
            err_n++;
            err_cyc = cyc;
            addr_at_err  = mem_addr4;
            wdata_at_err = mem_wdata4;
         end
         if (!busy4) finished = 1;
      end
      check("to_finished", 32'(finished), 32'd1);
      check("to_re_cycles", re_n, (sz == 2'b10) ? 0 : 4);
      check("to_we_cycles", we_n, (sz == 2'b10) ? 4 : 0);
      check("to_err_count", err_n, 1);
      check("to_err_cycle", err_cyc, 5);
      check("to_done_count", done_n, 0);
      check("to_mem_addr", addr_at_err, {a[31:2], 2'b00});
      if (sz == 2'b10) check("to_mem_wdata", wdata_at_err, wd);
   endtask

   initial begin
      logic [31:0] a, old;
      logic [1:0]  sz;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_re", 32'(mem_re), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;

      // Directed cases
      mem[0] = 32'h1122_3344;
      run_store(2'b00, 32'h0000_1002, 32'hAABB_CCDD, 0, 0, 0);
      check("sb_result", mem[0], 32'h11DD_3344);
      mem[0] = 32'h1234_5678;
      run_store(2'b01, 32'h0000_0002, 32'h0000_BEEF, 0, 0, 0);
      check("sh_result", mem[0], 32'hBEEF_5678);
      run_store(2'b10, 32'h0000_0008, 32'hDEAD_BEEF, 0, 0, 0);
      check("sw_result", mem[2], 32'hDEAD_BEEF);
      run_store(2'b01, 32'h0000_0001, 32'h1111_2222, 0, 0, 0);
      run_store(2'b10, 32'h0000_0006, 32'h3333_4444, 0, 0, 0);
      run_store(2'b11, 32'h0000_0010, 32'h5555_6666, 0, 0, 0);
      run_store(2'b00, 32'h0000_0023, 32'h0000_00A5, 5, 3, 1);
      run_store(2'b00, 32'h0000_0024, 32'h0000_005A, 0, 0, 0);

      // Timeout on the short-wait instance: read phase, then write phase
      run_timeout(2'b00, 32'h0000_0031, 32'h7777_8888);
      run_timeout(2'b10, 32'h0000_0040, 32'h9999_AAAA);

      // Reset while a word write is waiting for wready
      old = mem[16];
      @(negedge clk);
      start = 1'b1; size = 2'b10; addr = 32'h0000_0040; wdata = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_rst_we", 32'(mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_we", 32'(mem_we), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      check("mid_rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      check("mid_rst_mem", mem[16], old);
      run_store(2'b10, 32'h0000_0040, 32'hCAFE_F00D, 0, 1, 0);

      // Randomized stores
      for (int n = 0; n < 40; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
         end
         run_store(sz, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
